// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Single-clock FIFO with registered one-cycle read, occupancy count
//            and full/empty/almost flags. Define SFIFO_ERR_FLAGS_EN to add
//            sticky overflow/underflow outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int AF_LVL = DEPTH - 4,
    parameter int AE_LVL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty
`ifdef SFIFO_ERR_FLAGS_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(AF_LVL);
    localparam logic [c_CNT_W-1:0] c_AE_CNT   = c_CNT_W'(AE_LVL);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_rd_valid;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_full  = (r_cnt == c_FULL_CNT);
    assign w_empty = (r_cnt == '0);

    // A write into a full FIFO is allowed when a read frees the slot this edge.
    assign w_wr_acc = wr && (!w_full || rd);
    assign w_rd_acc = rd && !w_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // The read samples the old word even when the same slot is rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign data_out     = r_data_out;
    assign rd_valid     = r_rd_valid;
    assign fifo_cnt     = r_cnt;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_cnt >= c_AF_CNT);
    assign almost_empty = (r_cnt <= c_AE_CNT);

`ifdef SFIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && w_full && !rd) begin
                r_overflow <= 1'b1;
            end
            if (rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param (16 x 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic        clk;
    logic        rst;
    logic        wr;
    logic        rd;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        rd_valid;
    logic [5:0]  fifo_cnt;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
`ifdef SFIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q[$];

    sync_fifo_param #(
        .DATA_W (16),
        .DEPTH  (32),
        .AF_LVL (28),
        .AE_LVL (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .rd           (rd),
        .data_in      (data_in),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .fifo_cnt     (fifo_cnt),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef SFIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle and leave the bench 1 ns after the edge for sampling.
    task automatic cycle(input logic w, input logic r, input logic [15:0] d);
        wr      = w;
        rd      = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_d;
        logic        do_w;
        logic        do_r;
        int          sel;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0;
        @(posedge clk); #1;
        // reset has priority over simultaneous access
        cycle(1'b1, 1'b1, 16'hAAAA);
        rst = 1'b0;
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
`ifdef SFIFO_ERR_FLAGS_EN
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
`endif

        // fill with i*5, watching the almost_full threshold
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b0, 16'(i * 5));
            check("fill_cnt", 32'(fifo_cnt), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'((i + 1) >= 28));
            check("fill_valid", 32'(rd_valid), 32'd0);
        end
        check("fill_full", 32'(full), 32'd1);

        // write while full without read is dropped
        cycle(1'b1, 1'b0, 16'hDEAD);
        check("ovf_cnt", 32'(fifo_cnt), 32'd32);
`ifdef SFIFO_ERR_FLAGS_EN
        check("ovf_flag", 32'(overflow), 32'd1);
`endif

        // drain in order, watching almost_empty
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b1, 16'h0);
            check("drain_valid", 32'(rd_valid), 32'd1);
            check("drain_data", 32'(data_out), 32'(i * 5));
            check("drain_ae", 32'(almost_empty), 32'((31 - i) <= 4));
        end
        check("drain_empty", 32'(empty), 32'd1);

        // idle cycle: data_out holds, rd_valid drops
        cycle(1'b0, 1'b0, 16'h0);
        check("hold_valid", 32'(rd_valid), 32'd0);
        check("hold_data", 32'(data_out), 32'd155);

        // refill, then read+write while full
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b0, 16'(i * 5));
        end
        cycle(1'b1, 1'b1, 16'hBEEF);
        check("fullrw_valid", 32'(rd_valid), 32'd1);
        check("fullrw_data", 32'(data_out), 32'd0);
        check("fullrw_cnt", 32'(fifo_cnt), 32'd32);
        for (int i = 1; i <= 32; i++) begin
            cycle(1'b0, 1'b1, 16'h0);
            exp_d = (i == 32) ? 16'hBEEF : 16'(i * 5);
            check("fullrw_drain", 32'(data_out), 32'(exp_d));
        end
        check("fullrw_empty", 32'(empty), 32'd1);

        // read while empty is ignored
        cycle(1'b0, 1'b1, 16'h0);
        check("unf_valid", 32'(rd_valid), 32'd0);
        check("unf_cnt", 32'(fifo_cnt), 32'd0);
        check("unf_hold", 32'(data_out), 32'hBEEF);
`ifdef SFIFO_ERR_FLAGS_EN
        check("unf_flag", 32'(underflow), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
`endif

        // read+write while empty: write only, no fall-through
        cycle(1'b1, 1'b1, 16'h1234);
        check("emptyrw_valid", 32'(rd_valid), 32'd0);
        check("emptyrw_cnt", 32'(fifo_cnt), 32'd1);
        cycle(1'b0, 1'b1, 16'h0);
        check("emptyrw_rdv", 32'(rd_valid), 32'd1);
        check("emptyrw_data", 32'(data_out), 32'h1234);
        check("emptyrw_cnt0", 32'(fifo_cnt), 32'd0);

        // interleaved traffic across pointer wrap, occupancy kept in 1..31
        cycle(1'b1, 1'b0, 16'h7777);
        q.push_back(16'h7777);
        for (int k = 0; k < 100; k++) begin
            sel = (k * 7) % 3;
            if (q.size() <= 1) begin
                do_w = 1'b1; do_r = 1'b0;
            end else if (q.size() >= 31) begin
                do_w = 1'b0; do_r = 1'b1;
            end else begin
                do_w = (sel != 1);
                do_r = (sel != 0);
            end
            exp_d = 16'h0;
            if (do_r) exp_d = q.pop_front();
            if (do_w) q.push_back(16'(k * 37 + 3));
            cycle(do_w, do_r, 16'(k * 37 + 3));
            check("wrap_cnt", 32'(fifo_cnt), 32'(q.size()));
            check("wrap_valid", 32'(rd_valid), 32'(do_r));
            if (do_r) check("wrap_data", 32'(data_out), 32'(exp_d));
        end
        while (q.size() > 0) begin
            exp_d = q.pop_front();
            cycle(1'b0, 1'b1, 16'h0);
            check("wrap_tail", 32'(data_out), 32'(exp_d));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // mid-operation reset at occupancy 10
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 16'(16'h4000 + i));
        end
        check("pre_rst_cnt", 32'(fifo_cnt), 32'd10);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 16'h5555);
        rst = 1'b0;
        check("mrst_cnt", 32'(fifo_cnt), 32'd0);
        check("mrst_valid", 32'(rd_valid), 32'd0);
        check("mrst_empty", 32'(empty), 32'd1);
        check("mrst_dout", 32'(data_out), 32'd0);
`ifdef SFIFO_ERR_FLAGS_EN
        check("mrst_ovf", 32'(overflow), 32'd0);
        check("mrst_unf", 32'(underflow), 32'd0);
`endif
        cycle(1'b1, 1'b0, 16'h9ABC);
        cycle(1'b0, 1'b1, 16'h0);
        check("post_rst_data", 32'(data_out), 32'h9ABC);
        check("post_rst_cnt", 32'(fifo_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 32, number of storage locations (power of two, 4..1024).
REQ-003 The block SHALL have parameter AF_LVL, default DEPTH-4, occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LVL, default 4, occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-007 The block SHALL have port wr, input, 1 bit, write request.
REQ-008 The block SHALL have port rd, input, 1 bit, read request.
REQ-009 The block SHALL have port data_in, input, DATA_W bits, write data.
REQ-010 The block SHALL have port data_out, output, DATA_W bits, registered read data.
REQ-011 The block SHALL have port rd_valid, output, 1 bit, high for one cycle when data_out carries a newly read word.
REQ-012 The block SHALL have port fifo_cnt, output, clog2(DEPTH)+1 bits, current occupancy.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit, decoded combinationally from fifo_cnt.
REQ-014 When SFIFO_ERR_FLAGS_EN is defined, the block SHALL have ports overflow and underflow, each an output of 1 bit and sticky.

Function
REQ-015 Write accepted (wr_acc) SHALL be defined as wr && (!full || rd); on wr_acc, data_in is stored at wr_ptr and wr_ptr increments.
REQ-016 Read accepted (rd_acc) SHALL be defined as rd && !empty; on rd_acc, mem[rd_ptr] is registered onto data_out, rd_ptr increments, and rd_valid=1 on the following cycle.
REQ-017 Read latency SHALL be one clock: data_out and rd_valid are updated at the same edge on which rd_acc is sampled.
REQ-018 data_out SHALL hold its last value when no read is accepted, and rd_valid SHALL be 0 in that case.
REQ-019 Pointers SHALL be clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no special handling.
REQ-020 fifo_cnt SHALL increment by 1 on wr_acc only, decrement by 1 on rd_acc only, and hold when both or neither are accepted; it never exceeds DEPTH and never goes below 0.
REQ-021 When full and rd && wr, both SHALL be accepted: the oldest word is read, the new word is written into the freed slot, and fifo_cnt stays at DEPTH.
REQ-022 When empty and rd && wr, only the write SHALL be accepted: no fall-through, rd_valid=0, and fifo_cnt becomes 1.
REQ-023 A write while full without rd, and a read while empty, SHALL be ignored, with no pointer, count or memory change.
REQ-024 Flag decoding SHALL be: full = (fifo_cnt==DEPTH); empty = (fifo_cnt==0); almost_full = (fifo_cnt>=AF_LVL); almost_empty = (fifo_cnt<=AE_LVL).

Reset
REQ-025 On a rising clk edge with rst=1, the block SHALL set wr_ptr=0, rd_ptr=0, fifo_cnt=0, data_out=0 and rd_valid=0, and clear overflow/underflow if present.
REQ-026 After reset, empty and almost_empty SHALL read 1, and full and almost_full SHALL read 0.
REQ-027 Reset SHALL take priority over wr and rd in the same cycle, and a reset mid-operation SHALL discard all contents.
REQ-028 Memory contents SHALL NOT be reset.

Configuration
REQ-029 With SFIFO_ERR_FLAGS_EN defined, the block SHALL set overflow=1 on wr && full && !rd and set underflow=1 on rd && empty; both stay set until rst.
REQ-030 Without SFIFO_ERR_FLAGS_EN, the overflow/underflow ports and their logic SHALL be absent, and all other behaviour is identical.

Verification (DATA_W=16, DEPTH=32, AF_LVL=28, AE_LVL=4)
REQ-031 Fill-drain: reset, then write i*5 for i=0..31, then read 32 times; the bench SHALL see rd_valid on 32 cycles, data_out sequence 0,5,...,155, full=1 after the 32nd write, and empty=1 at the end.
REQ-032 Full plus simultaneous access: at fifo_cnt=32, drive wr=1, rd=1 with data_in=16'hBEEF; the bench SHALL see data_out = oldest word, fifo_cnt=32, and 16'hBEEF read out last.
REQ-033 Empty plus simultaneous access: at fifo_cnt=0, drive wr=1, rd=1 with data_in=16'h1234; the bench SHALL see rd_valid=0 and fifo_cnt=1, and the next read returns 16'h1234.
REQ-034 Thresholds: write 28 words, and the bench SHALL see almost_full=1 only from the 28th; read down to 4, and it SHALL see almost_empty=1 from fifo_cnt=4.
REQ-035 Wrap-around: run 100 interleaved writes/reads keeping occupancy between 1 and 31; the bench SHALL see data in order with no loss across the pointer wrap.
REQ-036 Error flags plus mid-operation reset (SFIFO_ERR_FLAGS_EN): write while full, then rd while empty; the bench SHALL see overflow=1 and underflow=1 sticky; then assert rst with fifo_cnt=10, and it SHALL see fifo_cnt=0, flags=0, rd_valid=0 on the next edge.
